// File: rtl/register_file_mp.sv
// Multi-port integer register file: NUM_READ_PORTS combinational reads, two write
// lanes (lane 1 wins on conflict), optional write-to-read bypass, and a clear sweep.
module register_file_mp #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_READ_PORTS = 2,
  parameter int BYPASS         = 1
) (
  input  logic                                     i_Clock,
  input  logic                                     i_Reset_N,
  input  logic                                     i_Enable,
  input  logic                                     i_Clear,
  input  logic [NUM_READ_PORTS*REG_ADDR_WIDTH-1:0] i_Read_Addr,
  output logic [NUM_READ_PORTS*XLEN-1:0]           o_Read_Data,
  input  logic                                     i_Write_Enable_0,
  input  logic [REG_ADDR_WIDTH-1:0]                i_Write_Addr_0,
  input  logic [XLEN-1:0]                          i_Write_Data_0,
  input  logic                                     i_Write_Enable_1,
  input  logic [REG_ADDR_WIDTH-1:0]                i_Write_Addr_1,
  input  logic [XLEN-1:0]                          i_Write_Data_1,
  output logic                                     o_Busy,
  output logic                                     o_Write_Collision,
  output logic                                     o_State
);

  localparam int                  DEPTH    = 1 << REG_ADDR_WIDTH;
  localparam [REG_ADDR_WIDTH-1:0] LAST_IDX = REG_ADDR_WIDTH'(DEPTH - 1);
  localparam [REG_ADDR_WIDTH-1:0] ONE_IDX  = REG_ADDR_WIDTH'(1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t                    state, state_nxt;
  logic [REG_ADDR_WIDTH-1:0] clear_idx, clear_idx_nxt;
  logic                      collision_nxt;
  logic                      active;
  logic                      wr0_act, wr1_act;
  logic [XLEN-1:0]           registers [DEPTH];

  // Writes and reads are only live in IDLE with the block enabled.
  assign active  = (state == ST_IDLE) && i_Enable;
  assign wr0_act = active && i_Write_Enable_0 && (i_Write_Addr_0 != '0);
  assign wr1_act = active && i_Write_Enable_1 && (i_Write_Addr_1 != '0);

  assign o_Busy  = (state == ST_CLEAR);
  assign o_State = state;

  always_comb begin
    state_nxt     = state;
    clear_idx_nxt = clear_idx;
    collision_nxt = wr0_act && wr1_act && (i_Write_Addr_0 == i_Write_Addr_1);
    case (state)
      ST_CLEAR: begin
        clear_idx_nxt = clear_idx + ONE_IDX;
        if (clear_idx == LAST_IDX) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        if (i_Enable && i_Clear) begin
          state_nxt     = ST_CLEAR;
          clear_idx_nxt = ONE_IDX;
        end
      end
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      state             <= ST_CLEAR;
      clear_idx         <= ONE_IDX;
      o_Write_Collision <= 1'b0;
    end else begin
      state             <= state_nxt;
      clear_idx         <= clear_idx_nxt;
      o_Write_Collision <= collision_nxt;
    end
  end

  // Storage has no reset; the sweep is what makes it deterministic.
  always_ff @(posedge i_Clock) begin
    if (state == ST_CLEAR) begin
      registers[clear_idx] <= '0;
    end else begin
      if (wr0_act) registers[i_Write_Addr_0] <= i_Write_Data_0;
      if (wr1_act) registers[i_Write_Addr_1] <= i_Write_Data_1;
    end
  end

  for (genvar k = 0; k < NUM_READ_PORTS; k++) begin : g_read
    logic [REG_ADDR_WIDTH-1:0] ra;
    logic [XLEN-1:0]           rd;

    assign ra = i_Read_Addr[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];

    always_comb begin
      rd = '0;
      if (active && (ra != '0)) begin
        if ((BYPASS != 0) && wr1_act && (i_Write_Addr_1 == ra)) begin
          rd = i_Write_Data_1;
        end else if ((BYPASS != 0) && wr0_act && (i_Write_Addr_0 == ra)) begin
          rd = i_Write_Data_0;
        end else begin
          rd = registers[ra];
        end
      end
    end

    assign o_Read_Data[k*XLEN +: XLEN] = rd;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: one bypassing and one non-bypassing instance share
// stimulus and are compared each cycle against an array-based reference model.
module tb_register_file_mp;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRP  = 2;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              clr = 1'b0;
  logic [NRP*AW-1:0] raddr = '0;
  logic              we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0]     wa0 = '0, wa1 = '0;
  logic [XLEN-1:0]   wd0 = '0, wd1 = '0;

  logic [NRP*XLEN-1:0] rdata_b, rdata_n;
  logic                busy_b, busy_n, coll_b, coll_n, st_b, st_n;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  logic [XLEN-1:0] mdl [DEPTH];
  int              busy_left;
  logic            coll_exp;

  always #5 clk = ~clk;

  register_file_mp #(.XLEN(XLEN), .REG_ADDR_WIDTH(AW), .NUM_READ_PORTS(NRP), .BYPASS(1)) dut_b (
    .i_Clock(clk), .i_Reset_N(rst_n), .i_Enable(en), .i_Clear(clr),
    .i_Read_Addr(raddr), .o_Read_Data(rdata_b),
    .i_Write_Enable_0(we0), .i_Write_Addr_0(wa0), .i_Write_Data_0(wd0),
    .i_Write_Enable_1(we1), .i_Write_Addr_1(wa1), .i_Write_Data_1(wd1),
    .o_Busy(busy_b), .o_Write_Collision(coll_b), .o_State(st_b)
  );

  register_file_mp #(.XLEN(XLEN), .REG_ADDR_WIDTH(AW), .NUM_READ_PORTS(NRP), .BYPASS(0)) dut_n (
    .i_Clock(clk), .i_Reset_N(rst_n), .i_Enable(en), .i_Clear(clr),
    .i_Read_Addr(raddr), .o_Read_Data(rdata_n),
    .i_Write_Enable_0(we0), .i_Write_Addr_0(wa0), .i_Write_Data_0(wd0),
    .i_Write_Enable_1(we1), .i_Write_Addr_1(wa1), .i_Write_Data_1(wd1),
    .o_Busy(busy_n), .o_Write_Collision(coll_n), .o_State(st_n)
  );

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] a, input bit byp);
    if (!en || busy_left > 0 || a == 0) return '0;
    if (byp && we1 && wa1 == a) return wd1;
    if (byp && we0 && wa0 == a) return wd0;
    return mdl[a];
  endfunction

  task automatic check_outputs();
    logic [AW-1:0] a;
    check("busy_b", {31'd0, busy_b}, {31'd0, busy_left > 0});
    check("busy_n", {31'd0, busy_n}, {31'd0, busy_left > 0});
    check("state_b", {31'd0, st_b}, {31'd0, busy_left > 0});
    check("coll_b", {31'd0, coll_b}, {31'd0, coll_exp});
    check("coll_n", {31'd0, coll_n}, {31'd0, coll_exp});
    for (int k = 0; k < NRP; k++) begin
      a = raddr[k*AW +: AW];
      check($sformatf("rd_byp%0d_x%0d", k, a), rdata_b[k*XLEN +: XLEN], exp_read(a, 1'b1));
      check($sformatf("rd_nob%0d_x%0d", k, a), rdata_n[k*XLEN +: XLEN], exp_read(a, 1'b0));
    end
  endtask

  task automatic update_model();
    if (!rst_n) begin
      busy_left = DEPTH - 1;
      coll_exp  = 1'b0;
    end else if (busy_left > 0) begin
      busy_left--;
      coll_exp = 1'b0;
    end else begin
      coll_exp = en && we0 && we1 && (wa0 == wa1) && (wa0 != 0);
      if (en) begin
        if (we0 && wa0 != 0) mdl[wa0] = wd0;
        if (we1 && wa1 != 0) mdl[wa1] = wd1;
        if (clr) begin
          busy_left = DEPTH - 1;
          foreach (mdl[i]) mdl[i] = '0;
        end
      end
    end
  endtask

  // Check this cycle's outputs at the falling edge, then advance past the rising edge.
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic drive(input logic e, input logic c, input logic [NRP*AW-1:0] ra,
                       input logic w0, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                       input logic w1, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1);
    en = e; clr = c; raddr = ra;
    we0 = w0; wa0 = a0; wd0 = d0;
    we1 = w1; wa1 = a1; wd1 = d1;
  endtask

  task automatic drive_random(input int en_pct, input int clr_pct);
    logic [AW-1:0] a0, a1;
    a0 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH - 1));
    a1 = ($urandom_range(0, 3) == 0) ? a0 : AW'($urandom_range(0, DEPTH - 1));
    drive($urandom_range(1, 100) <= en_pct, $urandom_range(1, 100) <= clr_pct,
          ($urandom_range(0, 2) == 0) ? {a1, a0} : NRP*AW'($urandom),
          $urandom_range(0, 1) == 1, a0, $urandom,
          $urandom_range(0, 1) == 1, a1, $urandom);
  endtask

  initial begin
    foreach (mdl[i]) mdl[i] = '0;
    busy_left = DEPTH - 1;
    coll_exp  = 1'b0;

    // reset held, then released: sweep of DEPTH-1 cycles with random traffic ignored
    repeat (3) step();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive_random(100, 0);
      step();
    end
    check("busy_after_sweep", {31'd0, busy_b}, 32'd0);

    // bypass: write x5 on port 0, read x5 on port 1 the same cycle
    drive(1, 0, {AW'(5), AW'(0)}, 1, AW'(5), 32'hDEADBEEF, 0, AW'(0), 32'h0);
    #1;
    check("bypass_same_cycle", rdata_b[XLEN +: XLEN], 32'hDEADBEEF);
    check("nobypass_old_value", rdata_n[XLEN +: XLEN], 32'h0);
    step();
    drive(1, 0, {AW'(5), AW'(0)}, 0, AW'(0), 32'h0, 0, AW'(0), 32'h0);
    #1;
    check("nobypass_next_cycle", rdata_n[XLEN +: XLEN], 32'hDEADBEEF);
    check("x0_port0", rdata_b[XLEN-1:0], 32'h0);
    step();

    // collision on x7: port 1 wins, flag for exactly one cycle
    drive(1, 0, {AW'(7), AW'(7)}, 1, AW'(7), 32'h11111111, 1, AW'(7), 32'h22222222);
    step();
    drive(1, 0, {AW'(7), AW'(7)}, 0, AW'(0), 32'h0, 0, AW'(0), 32'h0);
    #1;
    check("coll_set", {31'd0, coll_b}, 32'd1);
    check("x7_port1_wins", rdata_n[XLEN-1:0], 32'h22222222);
    step();
    check("coll_one_cycle", {31'd0, coll_b}, 32'd0);

    // both ports target x0: no write, no collision
    drive(1, 0, {AW'(0), AW'(0)}, 1, AW'(0), 32'hFFFFFFFF, 1, AW'(0), 32'hFFFFFFFF);
    step();
    drive(1, 0, {AW'(0), AW'(0)}, 0, AW'(0), 32'h0, 0, AW'(0), 32'h0);
    #1;
    check("x0_no_coll", {31'd0, coll_b}, 32'd0);
    check("x0_reads_zero", rdata_n[XLEN-1:0], 32'h0);
    step();

    // random traffic
    for (int i = 0; i < 300; i++) begin
      drive_random(90, 0);
      step();
    end

    // fill x1..x31, then clear with writes during the sweep
    for (int r = 1; r < DEPTH; r++) begin
      drive(1, 0, {AW'(r), AW'(r)}, 1, AW'(r), 32'hA5000000 | r, 0, AW'(0), 32'h0);
      step();
    end
    drive(1, 1, '0, 0, AW'(0), 32'h0, 0, AW'(0), 32'h0);
    step();
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive_random(100, 50);
      step();
    end

    // reset in the middle of a sweep restarts it
    drive(1, 1, '0, 0, AW'(0), 32'h0, 0, AW'(0), 32'h0);
    step();
    for (int i = 0; i < 10; i++) begin
      drive_random(100, 0);
      step();
    end
    rst_n = 1'b0;
    busy_left = DEPTH - 1;
    coll_exp  = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      drive_random(100, 0);
      step();
    end

    // disabled: writes ignored, reads zero
    for (int i = 0; i < 40; i++) begin
      drive_random(0, 50);
      step();
    end

    // mixed random traffic including occasional clears
    for (int i = 0; i < 400; i++) begin
      drive_random(90, 2);
      step();
    end

    // quiet readback of every register on both ports
    while (busy_left > 0) begin
      drive(1, 0, '0, 0, AW'(0), 32'h0, 0, AW'(0), 32'h0);
      step();
    end
    for (int r = 0; r < DEPTH; r++) begin
      drive(1, 0, {AW'(DEPTH - 1 - r), AW'(r)}, 0, AW'(0), 32'h0, 0, AW'(0), 32'h0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
